// File: rtl/pipeline_arbiter.sv
// pipeline_arbiter: round-robin arbiter feeding one shared fixed-latency pipeline,
// tracking a tag per stage so each result returns to the requester that issued it.
module pipeline_arbiter #(
    parameter int N_REQ = 4,
    parameter int INP_WIDTH = 2,
    parameter int OUT_WIDTH = 4,
    parameter int LATENCY = 3,
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW = $clog2(LATENCY + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*INP_WIDTH-1:0] req_a,
    input  logic [N_REQ*INP_WIDTH-1:0] req_b,
    input  logic [N_REQ*INP_WIDTH-1:0] req_c,
    output logic [INP_WIDTH-1:0]       pipe_a,
    output logic [INP_WIDTH-1:0]       pipe_b,
    output logic [INP_WIDTH-1:0]       pipe_c,
    output logic                       pipe_stall,
    input  logic [OUT_WIDTH-1:0]       pipe_x,
    output logic                       resp_valid,
    output logic [IDW-1:0]             resp_id,
    output logic [OUT_WIDTH-1:0]       resp_data,
    input  logic                       resp_ready,
    input  logic                       hold,
    output logic [CW-1:0]              in_flight
);

    logic [LATENCY-1:0] vld;
    logic [IDW-1:0]     id [LATENCY];
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     next_ptr;
    logic [IDW-1:0]     cand;
    logic               grant_any;
    logic [IDW-1:0]     grant_idx;

    assign resp_valid = vld[LATENCY-1];
    assign resp_id    = id[LATENCY-1];
    assign resp_data  = pipe_x;
    assign pipe_stall = vld[LATENCY-1] & ~resp_ready;

    // First pending requester at or after rr_ptr, wrapping past N_REQ-1
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!rst && !pipe_stall && !hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = IDW'((int'(rr_ptr) + k) % N_REQ);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        pipe_a    = '0;
        pipe_b    = '0;
        pipe_c    = '0;
        if (grant_any) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_idx == IDW'(i)) begin
                    req_ready[i] = 1'b1;
                    pipe_a = req_a[i*INP_WIDTH +: INP_WIDTH];
                    pipe_b = req_b[i*INP_WIDTH +: INP_WIDTH];
                    pipe_c = req_c[i*INP_WIDTH +: INP_WIDTH];
                end
            end
        end
    end

    always_comb begin
        in_flight = '0;
        for (int k = 0; k < LATENCY; k++) begin
            in_flight = in_flight + CW'(vld[k]);
        end
    end

    assign next_ptr = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Tags advance in lockstep with the external pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= '0;
            rr_ptr <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                id[k] <= '0;
            end
        end else begin
            if (!pipe_stall) begin
                vld[0] <= grant_any;
                id[0]  <= grant_idx;
                for (int k = 1; k < LATENCY; k++) begin
                    vld[k] <= vld[k-1];
                    id[k]  <= id[k-1];
                end
            end
            if (grant_any) begin
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_arbiter.sv
// tb_pipeline_arbiter: scenario tasks plus a response scoreboard, driven against
// a behavioural 3-stage a*b+c pipeline that honours pipe_stall.
module tb_pipeline_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int OW = 4;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*IW-1:0] req_a, req_b, req_c;
    logic [IW-1:0] pipe_a, pipe_b, pipe_c;
    logic          pipe_stall;
    logic [OW-1:0] pipe_x;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [OW-1:0] resp_data;
    logic          resp_ready;
    logic          hold;
    logic [1:0]    in_flight;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]    id;
        logic [OW-1:0] data;
    } resp_t;

    resp_t sb[$];
    int    glog[$];
    int    rlog[$];
    logic [OW-1:0] ps [L];
    int    mon_gi;
    resp_t mon_exp;

    pipeline_arbiter #(
        .N_REQ(N), .INP_WIDTH(IW), .OUT_WIDTH(OW), .LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
        .pipe_stall(pipe_stall), .pipe_x(pipe_x),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_ready(resp_ready),
        .hold(hold), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] f(logic [IW-1:0] a, logic [IW-1:0] b,
                                        logic [IW-1:0] c);
        return ({2'b00, a} * {2'b00, b}) + {2'b00, c};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++) ps[k] <= '0;
        end else if (!pipe_stall) begin
            ps[0] <= f(pipe_a, pipe_b, pipe_c);
            ps[1] <= ps[0];
            ps[2] <= ps[1];
        end
    end
    assign pipe_x = ps[2];

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (req_ready != '0) begin
                mon_gi = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) mon_gi = i;
                checks++;
                if (!$onehot(req_ready) || pipe_a !== req_a[mon_gi*IW +: IW] ||
                    pipe_b !== req_b[mon_gi*IW +: IW] ||
                    pipe_c !== req_c[mon_gi*IW +: IW]) begin
                    errors++;
                    $display("FAIL grant_operands: req_ready=%b pipe=%0d/%0d/%0d want requester %0d operands",
                             req_ready, pipe_a, pipe_b, pipe_c, mon_gi);
                end
                glog.push_back(mon_gi);
                sb.push_back(resp_t'{id: 2'(mon_gi),
                                     data: f(req_a[mon_gi*IW +: IW],
                                             req_b[mon_gi*IW +: IW],
                                             req_c[mon_gi*IW +: IW])});
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: id=%0d data=%0d, none outstanding",
                             resp_id, resp_data);
                end else begin
                    mon_exp = sb.pop_front();
                    rlog.push_back(int'(resp_id));
                    if (resp_id !== mon_exp.id || resp_data !== mon_exp.data) begin
                        errors++;
                        $display("FAIL resp_scoreboard: got id=%0d data=%0d want id=%0d data=%0d",
                                 resp_id, resp_data, mon_exp.id, mon_exp.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        hold = 1'b0;
        resp_ready = 1'b1;
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        req_c = 8'($urandom);
        step();
        step();
        rst = 1'b0;
        glog.delete();
        rlog.delete();
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        hold = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        while ((in_flight != 0 || sb.size() != 0) && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (in_flight !== 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: in_flight=%0d outstanding=%0d want 0/0",
                     in_flight, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        hold = 1'b0;
        resp_ready = 1'b1;
        req_a = 8'hFF;
        req_b = 8'hFF;
        req_c = 8'hFF;
        step();
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 0000", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_resp: got valid=%b id=%0d want 0/0", resp_valid, resp_id);
        end
        checks++;
        if (pipe_stall !== 1'b0 || in_flight !== 2'd0) begin
            errors++;
            $display("FAIL reset_stall_inflight: got %b/%0d want 0/0", pipe_stall, in_flight);
        end
        checks++;
        if ({pipe_a, pipe_b, pipe_c} !== 6'd0) begin
            errors++;
            $display("FAIL reset_pipe_ops: got %0d/%0d/%0d want 0/0/0", pipe_a, pipe_b, pipe_c);
        end
        req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req_a[1:0] = 2'd1;
        req_b[1:0] = 2'd1;
        req_c[1:0] = 2'd1;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        n = 1;
        #1;
        while (!resp_valid && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (n != 3 || resp_id !== 2'd0 || resp_data !== 4'd2) begin
            errors++;
            $display("FAIL single_resp: got cycle=%0d id=%0d data=%0d want 3/0/2",
                     n, resp_id, resp_data);
        end
        drain();
    endtask

    task automatic test_all_valid();
        int exp_g[6] = '{0, 1, 2, 3, 0, 1};
        int cnt;
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) req_valid = '0;
            #1;
            cnt = 0;
            for (int g = c - 3; g < c; g++) if (g >= 0 && g <= 5) cnt++;
            checks++;
            if (in_flight !== 2'(cnt)) begin
                errors++;
                $display("FAIL all_in_flight: cycle %0d got %0d want %0d", c, in_flight, cnt);
            end
            checks++;
            if (resp_valid !== (c >= 3 && c <= 8) ||
                (c >= 3 && c <= 8 && resp_id !== 2'((c - 3) % 4))) begin
                errors++;
                $display("FAIL all_resp: cycle %0d got valid=%b id=%0d want valid=%b id=%0d",
                         c, resp_valid, resp_id, (c >= 3 && c <= 8), (c - 3) % 4);
            end
            step();
        end
        drain();
        checks++;
        if (glog.size() != 6 || rlog.size() != 6) begin
            errors++;
            $display("FAIL all_counts: got %0d grants %0d resps want 6/6", glog.size(), rlog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (glog[i] != exp_g[i] || rlog[i] != exp_g[i]) begin
                    errors++;
                    $display("FAIL all_order[%0d]: got grant=%0d resp=%0d want %0d",
                             i, glog[i], rlog[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_r[6] = '{0, 1, 2, 3, 0, 1};
        logic [OW-1:0] d;
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) step();
        resp_ready = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin
            errors++;
            $display("FAIL bp_head: got valid=%b id=%0d want 1/2", resp_valid, resp_id);
        end
        d = resp_data;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pipe_stall !== 1'b1 || req_ready !== 4'b0000 ||
                resp_id !== 2'd2 || resp_data !== d) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got stall=%b ready=%b id=%0d data=%0d want 1/0000/2/%0d",
                         k, pipe_stall, req_ready, resp_id, resp_data, d);
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_throughput: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd3) begin
            errors++;
            $display("FAIL bp_next: got valid=%b id=%0d want 1/3", resp_valid, resp_id);
        end
        drain();
        checks++;
        if (rlog.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d responses want 6", rlog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rlog[i] != exp_r[i]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %0d want %0d", i, rlog[i], exp_r[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: got %b want 1000", req_ready);
        end
        step();
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_to_zero: got %b want 0001", req_ready);
        end
        step();
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_skip: got %b want 1000", req_ready);
        end
        step();
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 3; c++) step();
        req_valid = '0;
        #1;
        checks++;
        if (in_flight !== 2'd3) begin
            errors++;
            $display("FAIL rmid_pre: in_flight got %0d want 3", in_flight);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || in_flight !== 2'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_async: got valid=%b in_flight=%0d ready=%b want 0/0/0000",
                     resp_valid, in_flight, req_ready);
        end
        step();
        rst = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rmid_grant: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1) begin
            errors++;
            $display("FAIL rmid_resp: got valid=%b id=%0d want 1/1", resp_valid, resp_id);
        end
        drain();
    endtask

    task automatic test_hold();
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 3; c++) step();
        hold = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_flight !== 2'(3 - k) || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL hold_drain[%0d]: got in_flight=%0d ready=%b want %0d/0000",
                         k, in_flight, req_ready, 3 - k);
            end
            step();
        end
        hold = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL hold_resume: got %b want 1000", req_ready);
        end
        step();
        drain();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        hold = 1'b0;
        resp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        test_reset();
        test_single();
        test_all_valid();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
